buffered_dispatcher: RTL and testbench
======================================

# buffered_dispatcher

Parametrised dispatcher between rename and the issue queues. It absorbs a rename group into a small in-order staging FIFO. It then dispatches each micro-op to every issue queue named in its one-hot-or-multi-hot `iq_type` mask, tracking per-entry pending bits so that a micro-op can be accepted by different queues in different cycles. Entries retire from the FIFO in order once all their queues have accepted them, which decouples rename stalls from per-queue back-pressure.

## Interface
- `W`, default 3: rename/dispatch width (lanes per cycle).
- `NUM_IQ`, default 3: number of issue queues; `iq_type` bit q selects queue q.
- `DEPTH`, default 6: staging FIFO entries. Must satisfy `DEPTH >= W`; a power of two is not required.
- `DATA_W`, default 32: opaque micro-op payload width.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately.
- `io_flush`  in  1  synchronous pipeline kill.
- `io_ren_valid`  in  W  per-lane valid.
- `io_ren_iq_type`  in  W*NUM_IQ  lane i occupies bits [i*NUM_IQ +: NUM_IQ].
- `io_ren_bits`  in  W*DATA_W  lane payloads.
- `io_ren_ready`  out  1  whole-group accept.
- `io_dis_valid`  out  NUM_IQ*W  slot (q,w) at bit q*W+w.
- `io_dis_ready`  in  NUM_IQ*W  per-slot ready from queue q.
- `io_dis_bits`  out  W*DATA_W  payload of window entry w, shared by all queues.
- `io_occupancy`  out  clog2(DEPTH+1)  registered entry count.

## Operation
- State: circular array of DEPTH entries {payload, pend[NUM_IQ]}, plus `head`, `tail` (mod DEPTH) and `count`.
- Enqueue: `io_ren_ready = (DEPTH - count >= W) & ~io_flush`, computed from registered `count` only (no same-cycle bypass of dequeues). When valid and ready, valid lanes with nonzero `iq_type` are compacted in lane order into the FIFO at `tail`, with `pend = iq_type`. Lanes with `iq_type == 0` are accepted and dropped. `tail` advances by the number of written entries, wrapping mod DEPTH.
- Window: window entry w is FIFO slot `(head + w) mod DEPTH`, present when `w < count`. `io_dis_bits[w]` carries its payload and is don't-care when the entry is not present.
- Presentation: `pres[q][w] = (w < count) & pend_w[q]`.
- Per-queue in-order prefix rule: `io_dis_valid[q][w] = pres[q][w] & ~io_flush & AND over k<w with pres[q][k] of io_dis_ready[q][k]`. Queue q can therefore never accept a younger micro-op unless every older presented one is accepted in the same cycle. Valid depends combinationally on ready; the queues must not derive ready from valid.
- Fire: `fire[q][w] = io_dis_valid[q][w] & io_dis_ready[q][w]`. Each firing slot clears `pend_w[q]` at the clock edge.
- Retire: let `done_w = ~|(pend_w & ~fire[*][w])`. Dequeue count `deq` = length of the contiguous prefix of present window entries with `done_w`. `head` advances by `deq` mod DEPTH.
- Count update: `count <= count + enq - deq`. Simultaneous enqueue and dequeue is legal; the full and empty checks use pre-edge `count`.
- Flush: with `io_flush` high, all `io_dis_valid` and `io_ren_ready` are 0, and at the edge `head = tail = count = 0` and all pend bits clear. Flush overrides any enqueue, fire or retire in that cycle.

## Timing
- Reset values: `io_ren_ready = 1` (given `DEPTH >= W`), all `io_dis_valid = 0`, `io_occupancy = 0`, pointers 0.
- Release of `reset` takes effect at the next rising edge.
- Latency: a group accepted at edge N is presented on `io_dis_*` in cycle N+1. A minimum-latency path is 1 cycle from rename to issue queue.
- Retirement frees space at the edge, but `io_ren_ready` reflects the freed space only from the next cycle.
- `reset` asserted mid-operation empties the FIFO asynchronously; in-flight micro-ops are lost, and the same behaviour is expected of upstream.
- Throughput: up to W enqueues and W retires per cycle, sustained when all queues are ready.

## Test plan
- Reset/idle: hold `reset` low, then release -> `io_ren_ready = 1`, `io_occupancy = 0`, no `io_dis_valid` set.
- Single-type streaming: W=3, `iq_type` = 001, 010, 100, all ready -> each lane fires on queue 0, 1 and 2 respectively one cycle after acceptance; `io_occupancy` returns to 0.
- Multi-hot split: entry with `iq_type = 101`; queue 0 ready in cycle 1, queue 2 ready only in cycle 3 -> queue-0 fire in cycle 1 only, queue-2 fire in cycle 3, retire at the cycle-3 edge, occupancy 1 -> 0.
- Prefix rule: window entries 0 and 1 both type 001, `io_dis_ready[0] = 010` -> neither `io_dis_valid[0][0]` nor `io_dis_valid[0][1]` fires, and no retire.
- Full/wrap: DEPTH=6, W=3, all queues stalled, offer 3 groups -> groups 1 and 2 accepted, `io_ren_ready = 0` with occupancy 6. Then release the queues -> pointers wrap past slot 5 with correct in-order output.
- Flush with enqueue: 4 entries pending, `io_flush` high concurrent with a valid rename group -> that cycle shows `io_ren_ready = 0` and no dispatch valids, and the next cycle shows occupancy 0 with `io_ren_ready = 1`.

Source files
------------

// File: rtl/buffered_dispatcher.sv
// Staging FIFO between rename and the issue queues: absorbs whole rename groups,
// dispatches each entry to every queue in its iq_type mask, retires entries in order.
module buffered_dispatcher #(
  parameter int W      = 3,
  parameter int NUM_IQ = 3,
  parameter int DEPTH  = 6,
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_flush,
  input  logic [W-1:0]           io_ren_valid,
  input  logic [W*NUM_IQ-1:0]    io_ren_iq_type,
  input  logic [W*DATA_W-1:0]    io_ren_bits,
  output logic                   io_ren_ready,
  output logic [NUM_IQ*W-1:0]    io_dis_valid,
  input  logic [NUM_IQ*W-1:0]    io_dis_ready,
  output logic [W*DATA_W-1:0]    io_dis_bits,
  output logic [CNT_W-1:0]       io_occupancy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] payload_q [DEPTH];
  logic [NUM_IQ-1:0] pend_q    [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic [PTR_W-1:0]  win_idx     [W];
  logic [W-1:0]      win_present;
  logic [NUM_IQ-1:0] win_pend    [W];
  logic [NUM_IQ-1:0] win_fire    [W];
  logic [NUM_IQ*W-1:0] fire;
  logic [CNT_W-1:0]  deq_cnt, enq_cnt;
  logic [PTR_W-1:0]  lane_slot   [W];
  logic [W-1:0]      lane_wr;
  logic              ren_fire;

  // Pointer arithmetic modulo DEPTH; offsets never exceed DEPTH, so one subtraction suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  always_comb begin
    for (int w = 0; w < W; w++) begin
      win_idx[w]     = wrap_add(head_q, w);
      win_present[w] = (w < int'(count_q));
      win_pend[w]    = win_present[w] ? pend_q[win_idx[w]] : '0;
      io_dis_bits[w*DATA_W +: DATA_W] = payload_q[win_idx[w]];
    end
  end

  // Handshake: a slot transfers when valid & ready in the same cycle. Valid of a
  // younger slot depends combinationally on ready of every older presented slot of
  // that queue, so a queue only accepts an in-order prefix; queues must not derive
  // ready from valid.
  always_comb begin
    logic path_ok;
    path_ok      = 1'b0;
    io_dis_valid = '0;
    for (int q = 0; q < NUM_IQ; q++) begin
      path_ok = ~io_flush;
      for (int w = 0; w < W; w++) begin
        if (win_pend[w][q]) begin
          io_dis_valid[q*W+w] = path_ok;
          path_ok = path_ok & io_dis_ready[q*W+w];
        end
      end
    end
  end

  assign fire = io_dis_valid & io_dis_ready;

  always_comb begin
    logic run;
    run     = 1'b1;
    deq_cnt = '0;
    for (int w = 0; w < W; w++) begin
      win_fire[w] = '0;
      for (int q = 0; q < NUM_IQ; q++) win_fire[w][q] = fire[q*W+w];
      if (run && win_present[w] && ~|(win_pend[w] & ~win_fire[w]))
        deq_cnt = deq_cnt + 1'b1;
      else
        run = 1'b0;
    end
  end

  // Readiness uses only the registered count: freed space shows up a cycle later.
  assign io_ren_ready = ((DEPTH - int'(count_q)) >= W) && !io_flush;
  assign ren_fire     = io_ren_ready & (|io_ren_valid);
  assign io_occupancy = count_q;

  // Lanes with an empty iq_type are accepted but not stored; the rest are packed in lane order.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < W; i++) begin
      lane_wr[i]   = ren_fire & io_ren_valid[i] & (|io_ren_iq_type[i*NUM_IQ +: NUM_IQ]);
      lane_slot[i] = wrap_add(tail_q, int'(enq_cnt));
      if (lane_wr[i]) enq_cnt = enq_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        payload_q[d] <= '0;
        pend_q[d]    <= '0;
      end
    end else if (io_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int d = 0; d < DEPTH; d++) pend_q[d] <= '0;
    end else begin
      // Occupied window slots and free enqueue slots never overlap.
      for (int w = 0; w < W; w++)
        if (win_present[w]) pend_q[win_idx[w]] <= win_pend[w] & ~win_fire[w];
      for (int i = 0; i < W; i++) begin
        if (lane_wr[i]) begin
          payload_q[lane_slot[i]] <= io_ren_bits[i*DATA_W +: DATA_W];
          pend_q[lane_slot[i]]    <= io_ren_iq_type[i*NUM_IQ +: NUM_IQ];
        end
      end
      head_q  <= wrap_add(head_q, int'(deq_cnt));
      tail_q  <= wrap_add(tail_q, int'(enq_cnt));
      count_q <= count_q + enq_cnt - deq_cnt;
    end
  end
endmodule

// File: tb/tb_buffered_dispatcher.sv
// Bench for buffered_dispatcher: directed scenarios plus random traffic, checked by a
// queue-level reference model and a per-queue payload scoreboard.
module tb_buffered_dispatcher;
  localparam int W     = 3;
  localparam int NQ    = 3;
  localparam int DEPTH = 6;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = 2 + DW;
  localparam logic [NQ*W-1:0] ALL_RDY = '1;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_flush;
  logic [W-1:0]      io_ren_valid;
  logic [W*NQ-1:0]   io_ren_iq_type;
  logic [W*DW-1:0]   io_ren_bits;
  logic              io_ren_ready;
  logic [NQ*W-1:0]   io_dis_valid;
  logic [NQ*W-1:0]   io_dis_ready;
  logic [W*DW-1:0]   io_dis_bits;
  logic [CW-1:0]     io_occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] tag = 32'h100;

  // Reference model: entries in program order with outstanding queue masks.
  logic [DW-1:0] mpay [$];
  logic [NQ-1:0] mpend[$];
  // Scoreboard: {queue id, payload} in the order each queue must receive them.
  logic [EW-1:0] exp_q[$];

  buffered_dispatcher #(.W(W), .NUM_IQ(NQ), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_ren_valid(io_ren_valid), .io_ren_iq_type(io_ren_iq_type), .io_ren_bits(io_ren_bits),
    .io_ren_ready(io_ren_ready), .io_dis_valid(io_dis_valid), .io_dis_ready(io_dis_ready),
    .io_dis_bits(io_dis_bits), .io_occupancy(io_occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [W-1:0] v, input logic [W*NQ-1:0] t,
                       input logic [NQ*W-1:0] r, input logic f);
    @(posedge clock);
    #1;
    io_ren_valid   = v;
    io_ren_iq_type = t;
    io_dis_ready   = r;
    io_flush       = f;
    for (int i = 0; i < W; i++) begin
      io_ren_bits[i*DW +: DW] = tag;
      tag = tag + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, ALL_RDY, 1'b0);
  endtask

  task automatic sb_pop(input int q, input logic [DW-1:0] got);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && int'(exp_q[i][EW-1:DW]) == q) idx = i;
    n_checks++;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL sb_unexpected q%0d: got %0h expected nothing at %0t", q, got, $time);
    end else begin
      if (got !== exp_q[idx][DW-1:0]) begin
        n_fail++;
        $display("FAIL sb_payload q%0d: got %0h expected %0h at %0t", q, got, exp_q[idx][DW-1:0], $time);
      end
      exp_q.delete(idx);
    end
  endtask

  // Monitor: mid-cycle, compare against the model, then advance the model across the next edge.
  always @(negedge clock) begin : monitor
    int cnt;
    int deq;
    logic exp_rdy;
    logic blocked;
    logic [NQ*W-1:0] ev;
    logic [NQ-1:0] tmp;
    logic [NQ-1:0] lt;
    if (!reset) begin
      mpay.delete();
      mpend.delete();
      exp_q.delete();
    end else begin
      cnt     = mpay.size();
      exp_rdy = !io_flush && ((DEPTH - cnt) >= W);
      check("ren_ready", 64'(io_ren_ready), 64'(exp_rdy));
      check("occupancy", 64'(io_occupancy), 64'(cnt));
      ev = '0;
      for (int q = 0; q < NQ; q++) begin
        blocked = 1'b0;
        for (int w = 0; w < W && w < cnt; w++) begin
          if (mpend[w][q]) begin
            ev[q*W+w] = !io_flush && !blocked;
            if (!io_dis_ready[q*W+w]) blocked = 1'b1;
          end
        end
      end
      check("dis_valid", 64'(io_dis_valid), 64'(ev));
      for (int q = 0; q < NQ; q++)
        for (int w = 0; w < W; w++)
          if (io_dis_valid[q*W+w] && io_dis_ready[q*W+w])
            sb_pop(q, io_dis_bits[w*DW +: DW]);
      if (io_flush) begin
        mpay.delete();
        mpend.delete();
        exp_q.delete();
      end else begin
        for (int w = 0; w < W && w < cnt; w++) begin
          tmp = mpend[w];
          for (int q = 0; q < NQ; q++)
            if (ev[q*W+w] && io_dis_ready[q*W+w]) tmp[q] = 1'b0;
          mpend[w] = tmp;
        end
        deq = 0;
        while (mpay.size() > 0 && deq < W && mpend[0] == '0) begin
          void'(mpay.pop_front());
          void'(mpend.pop_front());
          deq++;
        end
        if (exp_rdy) begin
          for (int i = 0; i < W; i++) begin
            lt = io_ren_iq_type[i*NQ +: NQ];
            if (io_ren_valid[i] && lt != '0) begin
              mpay.push_back(io_ren_bits[i*DW +: DW]);
              mpend.push_back(lt);
              for (int q = 0; q < NQ; q++)
                if (lt[q]) exp_q.push_back({2'(q), io_ren_bits[i*DW +: DW]});
            end
          end
        end
      end
    end
  end

  initial begin
    reset          = 1'b0;
    io_flush       = 1'b0;
    io_ren_valid   = '0;
    io_ren_iq_type = '0;
    io_ren_bits    = '0;
    io_dis_ready   = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("reset_ren_ready", 64'(io_ren_ready), 64'(1));
    check("reset_occupancy", 64'(io_occupancy), 64'(0));
    check("reset_dis_valid", 64'(io_dis_valid), 64'(0));

    // Single-type streaming: lane i goes to queue i.
    drive(3'b111, {3'b100, 3'b010, 3'b001}, ALL_RDY, 1'b0);
    drive('0, '0, ALL_RDY, 1'b0);
    #1 check("stream_valid", 64'(io_dis_valid), 64'(9'b100_010_001));
    idle(1);
    #1 check("stream_empty", 64'(io_occupancy), 64'(0));

    // Multi-hot split across cycles.
    drive(3'b001, {3'b000, 3'b000, 3'b101}, '0, 1'b0);
    drive('0, '0, 9'b000_000_001, 1'b0);
    #1 check("split_c1_valid", 64'(io_dis_valid), 64'(9'b001_000_001));
    drive('0, '0, '0, 1'b0);
    #1 check("split_c2_valid", 64'(io_dis_valid), 64'(9'b001_000_000));
    drive('0, '0, 9'b001_000_000, 1'b0);
    #1 check("split_c3_occ", 64'(io_occupancy), 64'(1));
    idle(1);
    #1 check("split_retired", 64'(io_occupancy), 64'(0));

    // In-order prefix: ready only on the younger slot blocks both.
    drive(3'b011, {3'b000, 3'b001, 3'b001}, '0, 1'b0);
    drive('0, '0, 9'b000_000_010, 1'b0);
    #1 check("prefix_valid", 64'(io_dis_valid), 64'(9'b000_000_001));
    drive('0, '0, '0, 1'b0);
    #1 check("prefix_no_retire", 64'(io_occupancy), 64'(2));
    idle(3);

    // Full and wrap: stalled queues, three groups offered.
    drive(3'b111, {3'b011, 3'b110, 3'b101}, '0, 1'b0);
    drive(3'b111, {3'b100, 3'b010, 3'b001}, '0, 1'b0);
    drive(3'b111, {3'b111, 3'b001, 3'b010}, '0, 1'b0);
    #1;
    check("full_ren_ready", 64'(io_ren_ready), 64'(0));
    check("full_occ", 64'(io_occupancy), 64'(6));
    for (int i = 0; i < 6; i++) drive(3'b111, {3'b001, 3'b100, 3'b010}, ALL_RDY, 1'b0);
    idle(4);

    // Flush concurrent with a rename group.
    drive(3'b011, {3'b000, 3'b001, 3'b010}, '0, 1'b0);
    drive(3'b011, {3'b000, 3'b100, 3'b011}, '0, 1'b0);
    drive(3'b111, {3'b001, 3'b001, 3'b001}, ALL_RDY, 1'b1);
    #1;
    check("flush_ren_ready", 64'(io_ren_ready), 64'(0));
    check("flush_dis_valid", 64'(io_dis_valid), 64'(0));
    check("flush_pre_occ", 64'(io_occupancy), 64'(4));
    drive('0, '0, ALL_RDY, 1'b0);
    #1;
    check("flush_post_occ", 64'(io_occupancy), 64'(0));
    check("flush_post_ready", 64'(io_ren_ready), 64'(1));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [NQ*W-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? ALL_RDY : NQ*W'($urandom);
      drive(W'($urandom_range(0, 7)), (W*NQ)'($urandom), r, $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset while entries are pending.
    drive(3'b111, {3'b101, 3'b011, 3'b110}, '0, 1'b0);
    drive(3'b111, {3'b001, 3'b010, 3'b100}, '0, 1'b0);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("arst_occ", 64'(io_occupancy), 64'(0));
    check("arst_ren_ready", 64'(io_ren_ready), 64'(1));
    check("arst_dis_valid", 64'(io_dis_valid), 64'(0));
    @(posedge clock);
    #1 reset = 1'b1;
    idle(12);
    #1 check("drain_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
